// File: rtl/retire_ctrl_if.sv
// ROB-head / retire-control bundle: head status flows in, retire count and pipeline control flow out.
interface retire_ctrl_if #(
  parameter int N     = 3,
  parameter int CNT_W = 32
);
  localparam int VW = $clog2(N + 1);

  logic [VW-1:0]    outputs_valid;
  logic [N-1:0]     head_complete;
  logic [N-1:0]     head_mispred;
  logic [N-1:0]     head_halt;
  logic [VW-1:0]    num_retiring;
  logic             flush;
  logic             stall_dispatch;
  logic             halted;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output outputs_valid, head_complete, head_mispred, head_halt,
    input  num_retiring, flush, stall_dispatch, halted, retire_count
  );

  modport slave (
    input  outputs_valid, head_complete, head_mispred, head_halt,
    output num_retiring, flush, stall_dispatch, halted, retire_count
  );
endinterface

// File: rtl/retire_ctrl.sv
// In-order retirement: frees the complete ROB head prefix combinationally; flush/recover/halt sequencing
// and the retired-instruction counter are registered (flush one cycle after the mispredict retires).
module retire_ctrl #(
  parameter int N              = 3,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic         clock,
  input  logic         reset,
  retire_ctrl_if.slave rob
);
  localparam int VW = $clog2(N + 1);

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER, HALT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       rcv_cnt;
  logic [3:0]       rcv_cnt_nxt;
  logic [VW-1:0]    prefix_len;
  logic             scan_stop;
  logic             end_mispred;
  logic             end_halt;
  logic [VW-1:0]    num_ret;
  logic             flush_q;
  logic             stall_q;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;

  // Walk oldest-first; the first flagged entry still retires but closes the group.
  always_comb begin
    prefix_len  = '0;
    scan_stop   = 1'b0;
    end_mispred = 1'b0;
    end_halt    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!scan_stop) begin
        if ((VW'(i) < rob.outputs_valid) && rob.head_complete[i]) begin
          prefix_len = prefix_len + VW'(1);
          if (rob.head_halt[i]) begin
            end_halt  = 1'b1;
            scan_stop = 1'b1;
          end else if (rob.head_mispred[i]) begin
            end_mispred = 1'b1;
            scan_stop   = 1'b1;
          end
        end else begin
          scan_stop = 1'b1;
        end
      end
    end
  end

  // Gated by reset so nothing retires while the block is held in reset.
  assign num_ret = (reset && (state == RUN)) ? prefix_len : '0;

  always_comb begin
    state_nxt   = state;
    rcv_cnt_nxt = rcv_cnt;
    case (state)
      RUN: begin
        if (end_halt)         state_nxt = HALT;
        else if (end_mispred) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt   = RECOVER;
        rcv_cnt_nxt = 4'(RECOVER_CYCLES - 1);
      end
      RECOVER: begin
        if (rcv_cnt == 4'd0) state_nxt = RUN;
        else                 rcv_cnt_nxt = rcv_cnt - 4'd1;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      rcv_cnt  <= '0;
      flush_q  <= 1'b0;
      stall_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state    <= state_nxt;
      rcv_cnt  <= rcv_cnt_nxt;
      flush_q  <= (state_nxt == FLUSH);
      stall_q  <= (state_nxt == FLUSH) || (state_nxt == RECOVER);
      halted_q <= (state_nxt == HALT);
      count_q  <= count_q + CNT_W'(num_ret);
    end
  end

  assign rob.num_retiring   = num_ret;
  assign rob.flush          = flush_q;
  assign rob.stall_dispatch = stall_q;
  assign rob.halted         = halted_q;
  assign rob.retire_count   = count_q;
endmodule

// File: tb/tb_retire_ctrl.sv
// Scoreboarded random + directed bench for retire_ctrl; a narrow-counter instance shares the stimulus.
module tb_retire_ctrl;
  localparam int N  = 3;
  localparam int RC = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  retire_ctrl_if #(.N(N), .CNT_W(32)) if_a ();
  retire_ctrl_if #(.N(N), .CNT_W(4))  if_b ();

  retire_ctrl #(.N(N), .RECOVER_CYCLES(RC), .CNT_W(32)) u_dut (
    .clock(clock), .reset(reset), .rob(if_a)
  );
  retire_ctrl #(.N(N), .RECOVER_CYCLES(RC), .CNT_W(4)) u_dut_w4 (
    .clock(clock), .reset(reset), .rob(if_b)
  );

  assign if_b.outputs_valid = if_a.outputs_valid;
  assign if_b.head_complete = if_a.head_complete;
  assign if_b.head_mispred  = if_a.head_mispred;
  assign if_b.head_halt     = if_a.head_halt;

  typedef struct {
    int          nr;
    bit          fl;
    bit          st;
    bit          ha;
    int unsigned cnt;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  // Reference model: stall cycles still owed, halted flag, running total.
  int          m_stall  = 0;
  bit          m_halted = 1'b0;
  int unsigned m_total  = 0;
  int          p_nr     = 0;
  int          p_end    = 0;

  function automatic void scan(input int ov, input logic [N-1:0] c, input logic [N-1:0] m,
                               input logic [N-1:0] h, output int nr, output int ending);
    nr = 0;
    ending = 0;
    for (int i = 0; i < N; i++) begin
      if (i >= ov || !c[i]) break;
      nr++;
      if (h[i]) begin ending = 2; break; end
      if (m[i]) begin ending = 1; break; end
    end
  endfunction

  task automatic chk(input string nm, input int c, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic cycle(input bit rst_val, input int ov, input logic [N-1:0] c,
                       input logic [N-1:0] m, input logic [N-1:0] h);
    exp_t e;
    int   nr;
    int   ending;
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      m_total += p_nr;
      if (m_stall > 0)     m_stall--;
      else if (p_end == 1) m_stall = 1 + RC;
      else if (p_end == 2) m_halted = 1'b1;
    end
    reset = rst_val;
    if (!rst_val) begin
      m_stall  = 0;
      m_halted = 1'b0;
      m_total  = 0;
    end
    if_a.outputs_valid = 2'(ov);
    if_a.head_complete = c;
    if_a.head_mispred  = m;
    if_a.head_halt     = h;
    if (rst_val && !m_halted && m_stall == 0) scan(ov, c, m, h, nr, ending);
    else begin
      nr = 0;
      ending = 0;
    end
    p_nr  = nr;
    p_end = ending;
    e.nr  = nr;
    e.fl  = (m_stall == 1 + RC);
    e.st  = (m_stall > 0);
    e.ha  = m_halted;
    e.cnt = m_total;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("num_retiring",   e.cyc, longint'(if_a.num_retiring),   longint'(e.nr));
      chk("flush",          e.cyc, longint'(if_a.flush),          longint'(e.fl));
      chk("stall_dispatch", e.cyc, longint'(if_a.stall_dispatch), longint'(e.st));
      chk("halted",         e.cyc, longint'(if_a.halted),         longint'(e.ha));
      chk("retire_count",   e.cyc, longint'(if_a.retire_count),   longint'(e.cnt));
      chk("retire_count_w4", e.cyc, longint'(if_b.retire_count),  longint'(e.cnt % 16));
      chk("w4_num_retiring", e.cyc, longint'(if_b.num_retiring),  longint'(e.nr));
    end
  end

  initial begin
    if_a.outputs_valid = '0;
    if_a.head_complete = '0;
    if_a.head_mispred  = '0;
    if_a.head_halt     = '0;

    cycle(0, 3, 3'b111, 3'b000, 3'b000);
    cycle(0, 3, 3'b111, 3'b000, 3'b000);
    // Full-width retirement, then drive the 4-bit counter through 14 -> 17 mod 16.
    repeat (4) cycle(1, 3, 3'b111, 3'b000, 3'b000);
    cycle(1, 2, 3'b111, 3'b000, 3'b000);
    cycle(1, 3, 3'b111, 3'b000, 3'b000);
    cycle(1, 3, 3'b101, 3'b000, 3'b000);
    cycle(1, 1, 3'b111, 3'b000, 3'b000);
    cycle(1, 0, 3'b111, 3'b111, 3'b111);
    // Mispredict at index 1, flags held high during flush/recover.
    cycle(1, 3, 3'b111, 3'b010, 3'b000);
    repeat (3) cycle(1, 3, 3'b111, 3'b111, 3'b000);
    cycle(1, 3, 3'b111, 3'b000, 3'b000);
    // Reset pulsed while recovering.
    cycle(1, 3, 3'b111, 3'b001, 3'b000);
    cycle(1, 3, 3'b111, 3'b000, 3'b000);
    cycle(1, 3, 3'b111, 3'b000, 3'b000);
    cycle(0, 3, 3'b111, 3'b000, 3'b000);
    cycle(1, 2, 3'b011, 3'b000, 3'b000);
    // Halt on the oldest entry beats a younger mispredict.
    cycle(1, 3, 3'b111, 3'b100, 3'b001);
    repeat (4) cycle(1, 3, 3'b111, 3'($urandom), 3'($urandom));
    cycle(1, 3, 3'b111, 3'b010, 3'b010);
    cycle(0, 0, 3'b000, 3'b000, 3'b000);

    for (int k = 0; k < 600; k++) begin
      bit             r;
      logic [N-1:0]   c;
      logic [N-1:0]   m;
      logic [N-1:0]   h;
      r = !(($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 7) == 0));
      c = 3'($urandom) | 3'($urandom);
      m = ($urandom_range(0, 7) == 0)  ? 3'($urandom) : 3'b000;
      h = ($urandom_range(0, 11) == 0) ? 3'($urandom) : 3'b000;
      cycle(r, $urandom_range(0, 3), c, m, h);
    end

    repeat (2) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/retire_ctrl.md
RETIRE_CTRL -- requirements
Module: retire_ctrl

Interface
REQ-001 The block SHALL have parameter N, default `N (3 in all scenarios below); retire width, equal to the ROB output width.
REQ-002 The block SHALL have parameter RECOVER_CYCLES, default 2; dispatch-stall cycles following a flush, legal range 1..15.
REQ-003 The block SHALL have parameter CNT_W, default 32; width of the retired-instruction counter.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port outputs_valid, input, clog2(N+1), count of valid ROB head entries, oldest-first from index 0.
REQ-007 The block SHALL have port head_complete, input, N, per-entry "executed and ready to retire" flag.
REQ-008 The block SHALL have port head_mispred, input, N, per-entry "mispredicted branch" flag.
REQ-009 The block SHALL have port head_halt, input, N, per-entry "halt instruction" flag.
REQ-010 The block SHALL have port num_retiring, output, clog2(N+1), entries the ROB frees this cycle (combinational).
REQ-011 The block SHALL have port flush, output, 1, one-cycle pipeline squash pulse (registered).
REQ-012 The block SHALL have port stall_dispatch, output, 1, high while flushing or recovering (registered).
REQ-013 The block SHALL have port halted, output, 1, high once a halt has retired (registered).
REQ-014 The block SHALL have port retire_count, output, CNT_W, total instructions retired since reset (registered).

Function
REQ-015 The block SHALL use FSM states RUN, FLUSH, RECOVER and HALT, held in a state register.
REQ-016 The block SHALL, in RUN, compute num_retiring as the length of the longest prefix i = 0..k-1 with i < outputs_valid and head_complete[i]=1.
REQ-017 The block SHALL, in RUN, truncate the prefix inclusively at the first entry whose head_mispred or head_halt is set; younger entries do not retire that cycle.
REQ-018 The block SHALL ignore head_* bits at indices >= outputs_valid.
REQ-019 The block SHALL transition RUN->FLUSH when the retiring prefix ends in a mispredict; the flush rises the next cycle, 1-cycle latency.
REQ-020 The block SHALL transition RUN->HALT when the retiring prefix ends in a halt.
REQ-021 The block SHALL obey the first flagged entry when an entry carries both flags, or when several flags appear; halt wins only when both flags are on the same entry.
REQ-022 The block SHALL, in FLUSH, drive num_retiring=0, flush=1 and stall_dispatch=1 for exactly 1 cycle, then go to RECOVER.
REQ-023 The block SHALL, in RECOVER, drive num_retiring=0 and stall_dispatch=1, with a down-counter loaded with RECOVER_CYCLES-1 on FLUSH->RECOVER; RECOVER->RUN occurs when the counter reads 0.
REQ-024 The block SHALL keep stall_dispatch high for exactly 1+RECOVER_CYCLES cycles per mispredict.
REQ-025 The block SHALL make HALT terminal: num_retiring=0, halted=1, flush=0, stall_dispatch=0, left only by reset.
REQ-026 The block SHALL update retire_count <= retire_count + num_retiring every cycle, wrapping modulo 2^CNT_W without saturation.
REQ-027 The block SHALL count the retiring mispredicted branch or halt itself in retire_count.
REQ-028 The block SHALL keep num_retiring <= outputs_valid at all times and never assert it for an incomplete entry.
REQ-029 The block SHALL hold num_retiring=0 with no state change when outputs_valid=0 (ROB empty).
REQ-030 The block SHALL not raise a new flush if head_mispred is asserted during FLUSH or RECOVER, since no retirement occurs there.

Reset
REQ-031 The block SHALL, while reset=0, asynchronously force state=RUN, the recover counter to 0, flush=0, stall_dispatch=0, halted=0 and retire_count=0.
REQ-032 The block SHALL keep num_retiring=0 while reset=0.
REQ-033 The block SHALL abort any in-progress FLUSH, RECOVER or HALT when reset asserts mid-operation; the first rising edge after deassertion evaluates in RUN.

Verification
REQ-034 The bench SHALL cover outputs_valid=3, complete=3'b111, no flags -> num_retiring=3 and retire_count +3 next cycle; repeat 4 cycles -> retire_count=12.
REQ-035 The bench SHALL cover outputs_valid=3, complete=3'b101 -> num_retiring=1 (gap at index 1); outputs_valid=1, complete=3'b111 -> num_retiring=1.
REQ-036 The bench SHALL cover outputs_valid=3, complete=3'b111, mispred=3'b010 -> num_retiring=2, then flush=1 for 1 cycle and stall_dispatch=1 for 3 cycles (RECOVER_CYCLES=2), num_retiring=0 throughout, then RUN resumes.
REQ-037 The bench SHALL cover complete=3'b111, mispred=3'b100, halt=3'b001 -> num_retiring=1, halted=1 next cycle, no flush, num_retiring=0 thereafter regardless of inputs.
REQ-038 The bench SHALL cover reset=0 pulsed during RECOVER (between clock edges) -> outputs clear immediately and retire_count=0; after release, complete=3'b011 with outputs_valid=2 -> num_retiring=2.
REQ-039 The bench SHALL cover CNT_W=4 with retire_count=14 and num_retiring=3 -> retire_count=1 (wrap).
